// File: rtl/data_memory_ram.sv
// data_memory_ram: single-clock RAM with one registered read port and one
// write port, sized by DATA_WIDTH/ADDR_WIDTH/DEPTH. The array has no reset.
// A sequenced zero-fill clears it instead, one word per cycle, after reset and
// whenever clear is pulsed. This lets the array map onto block RAM.
//
// Ports:
//   clk            system clock, all state updates on posedge
//   reset          synchronous active-high reset
//   clear          single-cycle request to zero-fill the whole array
//   ready          high when reads/writes are accepted, low while filling
//   rd_en          read request
//   read_address   read address
//   data_out       registered read data (out-of-range reads return 0)
//   rd_valid       pulses one cycle after an accepted read
//   write          write request (out-of-range writes are dropped)
//   write_address  write address
//   data_in        write data
//
// When a read and a write hit the same in-range address in one cycle, the
// read returns data_in if WRITE_FIRST=1, and the old word otherwise.
module data_memory_ram #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DEPTH       = 256,
  parameter bit          WRITE_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] data_in
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // If DEPTH fills the whole address space, every address is in range and
  // DEPTH itself cannot be represented in ADDR_WIDTH bits.
  localparam bit FULL = (64'(DEPTH) == (64'd1 << ADDR_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = FULL ? '0 : ADDR_WIDTH'(DEPTH);

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                    ready_q;
  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   data_out_q, rd_data_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_in_range, rd_in_range;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  assign wr_in_range = FULL || (write_address < DEPTH_A);
  assign rd_in_range = FULL || (read_address  < DEPTH_A);
  assign clr_addr_d  = clr_addr_q + 1'b1;

  // The fill and user writes share one write port. The fill owns it in CLEAR.
  // A user write is dropped in the cycle clear is taken.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (state_q == S_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
      end else if (!clear && write && wr_in_range) begin
        mem_we    = 1'b1;
        mem_waddr = write_address;
        mem_wdata = data_in;
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_in_range) begin
      if (WRITE_FIRST && write && (write_address == read_address))
        rd_data_d = data_in;
      else
        rd_data_d = mem[read_address[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          rd_valid_q <= 1'b0;
          if (clear) begin
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_d;
            if (clr_addr_q == LAST_A) begin
              state_q <= S_READY;
              ready_q <= 1'b1;
            end
          end
        end
        S_READY: begin
          if (clear) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
          end else begin
            rd_valid_q <= rd_en;
            if (rd_en)
              data_out_q <= rd_data_d;
          end
        end
        default: begin
          state_q    <= S_CLEAR;
          clr_addr_q <= '0;
          ready_q    <= 1'b0;
          rd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign rd_valid = rd_valid_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_data_memory_ram.sv
// Directed bench for data_memory_ram. Three instances share the same inputs.
// u_wf uses the defaults (256 words, write-first). u_rf is 256 words,
// read-first. u_d200 is 200 words, which covers the out-of-range handling.
module tb_data_memory_ram;

  logic       clk = 1'b0;
  logic       reset, clear, rd_en, write;
  logic [7:0] read_address, write_address, data_in;

  logic       ready_wf, ready_rf, ready_d2;
  logic       rdv_wf, rdv_rf, rdv_d2;
  logic [7:0] dout_wf, dout_rf, dout_d2;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  data_memory_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .WRITE_FIRST(1'b1)) u_wf (
    .clk(clk), .reset(reset), .clear(clear), .ready(ready_wf),
    .rd_en(rd_en), .read_address(read_address), .data_out(dout_wf), .rd_valid(rdv_wf),
    .write(write), .write_address(write_address), .data_in(data_in));

  data_memory_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .WRITE_FIRST(1'b0)) u_rf (
    .clk(clk), .reset(reset), .clear(clear), .ready(ready_rf),
    .rd_en(rd_en), .read_address(read_address), .data_out(dout_rf), .rd_valid(rdv_rf),
    .write(write), .write_address(write_address), .data_in(data_in));

  data_memory_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .WRITE_FIRST(1'b1)) u_d200 (
    .clk(clk), .reset(reset), .clear(clear), .ready(ready_d2),
    .rd_en(rd_en), .read_address(read_address), .data_out(dout_d2), .rd_valid(rdv_d2),
    .write(write), .write_address(write_address), .data_in(data_in));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one posedge. Sampling and driving both happen 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 1'b0; write = 1'b0; clear = 1'b0;
  endtask

  // Count posedges after a fill starts and check ready around the expected rise.
  task automatic fill_wait(input string tag);
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 1 || i == 255) check({tag, "_rdy_lo"}, ready_wf, 1'b0);
      if (i == 128)           check({tag, "_rdv_fill"}, rdv_wf, 1'b0);
      if (i == 256)           check({tag, "_rdy_hi"}, ready_wf, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1; idle();
    read_address = '0; write_address = '0; data_in = '0;
    tick(); tick();
    check("rst_ready", ready_wf, 1'b0);
    check("rst_rdv",   rdv_wf,   1'b0);
    check("rst_dout",  dout_wf,  8'h00);
    check("rst_ready200", ready_d2, 1'b0);

    // Initial fill after reset release.
    reset = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 199) check("d200_rdy_lo", ready_d2, 1'b0);
      if (i == 200) check("d200_rdy_hi", ready_d2, 1'b1);
      if (i == 255) check("init_rdy_lo", ready_wf, 1'b0);
      if (i == 256) begin
        check("init_rdy_hi", ready_wf, 1'b1);
        check("init_rdy_rf", ready_rf, 1'b1);
      end
    end

    // Every word reads back as zero, each valid one cycle after rd_en.
    for (int a = 0; a < 256; a++) begin
      rd_en = 1'b1; read_address = 8'(a);
      tick();
      check("zero_rd", {23'd0, rdv_wf, dout_wf}, {23'd0, 1'b1, 8'h00});
    end
    idle(); tick();
    check("idle_rdv", rdv_wf, 1'b0);

    // Write, then read the next cycle.
    write = 1'b1; write_address = 8'h10; data_in = 8'hA5;
    tick();
    write = 1'b0; rd_en = 1'b1; read_address = 8'h10;
    tick();
    check("wr_rd_data", dout_wf, 8'hA5);
    check("wr_rd_vld",  rdv_wf,  1'b1);
    idle(); tick();
    check("wr_rd_idle_vld",  rdv_wf,  1'b0);
    check("wr_rd_idle_hold", dout_wf, 8'hA5);

    // Collision: 0x20 holds 0x11, then a write of 0x3C and a read of 0x20 share a cycle.
    write = 1'b1; write_address = 8'h20; data_in = 8'h11;
    tick();
    rd_en = 1'b1; read_address = 8'h20; data_in = 8'h3C;
    tick();
    check("coll_wf", dout_wf, 8'h3C);
    check("coll_rf", dout_rf, 8'h11);
    write = 1'b0;
    tick();
    check("coll_wf_after", dout_wf, 8'h3C);
    check("coll_rf_after", dout_rf, 8'h3C);
    idle(); tick();

    // Out-of-range on the 200-word instance.
    write = 1'b1; write_address = 8'hC7; data_in = 8'h5A;
    tick();
    write_address = 8'hC8; data_in = 8'hFF;
    tick();
    write = 1'b0; rd_en = 1'b1; read_address = 8'hC8;
    tick();
    check("oor_data", dout_d2, 8'h00);
    check("oor_vld",  rdv_d2,  1'b1);
    check("inr_c8_256", dout_wf, 8'hFF);
    read_address = 8'hC7;
    tick();
    check("oor_neighbour", dout_d2, 8'h5A);
    idle(); tick();

    // Fill 0..7 with nonzero data, then clear together with a write and a read.
    for (int a = 0; a < 8; a++) begin
      write = 1'b1; write_address = 8'(a); data_in = 8'(a + 8'h41);
      tick();
    end
    write = 1'b0; rd_en = 1'b1; read_address = 8'h05;
    tick();
    check("pre_clr_05", dout_wf, 8'h46);
    clear = 1'b1; write = 1'b1; write_address = 8'h05; data_in = 8'h77;
    rd_en = 1'b1; read_address = 8'h03;
    tick();
    check("clr_rdy_fall", ready_wf, 1'b0);
    check("clr_rd_drop",  rdv_wf,   1'b0);
    check("clr_dout_hold", dout_wf, 8'h46);
    clear = 1'b0; write = 1'b0; read_address = 8'h05;
    fill_wait("clr");
    rd_en = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd_en = 1'b1; read_address = 8'(a);
      tick();
      check("post_clr_rd", {23'd0, rdv_wf, dout_wf}, {23'd0, 1'b1, 8'h00});
    end
    idle(); tick();

    // Reset at fill count 100 restarts the fill.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("mid_fill_rdy", ready_wf, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_dout", dout_wf, 8'h00);
    fill_wait("rstfill");

    // Clear at fill count 50 extends the fill.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    fill_wait("clrfill");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
